fc_layer_link: RTL

Inter-layer transfer sequencer between two consecutive `fc_layer` instances in an MLP top. When the upstream layer finishes its crossbar computation, the block triggers its function unit, captures the serial `o_func_data` stream, and writes it element by element into the downstream layer's input buffer. It then pulses the downstream `i_start`. It replaces the per-layer `i_ibuf_*`, `i_func_start`, `i_next_busy` and `i_start` top-level ports with a self-timed chain.

---
 rtl/fc_pkg.sv | 21 ++
 rtl/fc_layer_link.sv | 134 +++++++++++++
 2 files changed

// File: rtl/fc_pkg.sv
// Shared types and helpers for the fc_layer MLP datapath.
// Used by fc_layer and by the inter-layer transfer link.
package fc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_NEXT,
        S_FSTART,
        S_LAT,
        S_STREAM,
        S_NSTART
    } link_state_t;

    // Width of the function-latency counter (latency range 0..15)
    localparam int LAT_W = 4;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_layer_link.sv
// Self-timed transfer of one layer's function output
// into the next layer's input buffer, then kicks it off.
module fc_layer_link
    import fc_pkg::*;
#(
    parameter int datatype_size = 2,
    parameter int vector_size   = 784,
    parameter int func_latency  = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_prev_done,
    input  logic [datatype_size-1:0]         i_func_data,
    input  logic                             i_next_busy,
    output logic                             o_func_start,
    output logic                             o_busy,
    output logic                             o_ibuf_we,
    output logic [datatype_size-1:0]         o_ibuf_wr_data,
    output logic [addr_w(vector_size)-1:0]   o_ibuf_addr,
    output logic                             o_start
);

    localparam int             AW       = addr_w(vector_size);
    localparam logic [AW-1:0]  LAST     = AW'(vector_size - 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(func_latency);
    localparam bit             ZERO_LAT = (func_latency == 0);
    localparam bit             ONE_LAT  = (func_latency == 1);
    localparam bit             ONE_ELEM = (vector_size == 1);

    link_state_t               state_q;
    logic                      pending_q;
    logic [AW-1:0]             idx_q;
    logic [LAT_W-1:0]          lat_q;
    logic                      fstart_q;
    logic                      busy_q;
    logic                      we_q;
    logic [datatype_size-1:0]  wdata_q;
    logic [AW-1:0]             addr_q;
    logic                      start_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            idx_q     <= '0;
            lat_q     <= '0;
            fstart_q  <= 1'b0;
            busy_q    <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            addr_q    <= '0;
            start_q   <= 1'b0;
        end else begin
            fstart_q <= 1'b0;
            we_q     <= 1'b0;
            start_q  <= 1'b0;

            // A request arriving mid-transfer is remembered once
            if (i_prev_done && (state_q != S_IDLE)) begin
                pending_q <= 1'b1;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (i_prev_done || pending_q) begin
                        pending_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_WAIT_NEXT;
                    end
                end
                S_WAIT_NEXT: begin
                    if (!i_next_busy) begin
                        fstart_q <= 1'b1;
                        state_q  <= S_FSTART;
                    end
                end
                S_FSTART: begin
                    lat_q <= LAT_INIT;
                    idx_q <= '0;
                    if (ZERO_LAT) begin
                        // First element is already valid this cycle
                        we_q    <= 1'b1;
                        addr_q  <= '0;
                        wdata_q <= i_func_data;
                        if (ONE_ELEM) begin
                            state_q <= S_NSTART;
                        end else begin
                            idx_q   <= AW'(1);
                            state_q <= S_STREAM;
                        end
                    end else if (ONE_LAT) begin
                        state_q <= S_STREAM;
                    end else begin
                        state_q <= S_LAT;
                    end
                end
                S_LAT: begin
                    lat_q <= lat_q - 4'd1;
                    if (lat_q <= 4'd2) begin
                        state_q <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    we_q    <= 1'b1;
                    addr_q  <= idx_q;
                    wdata_q <= i_func_data;
                    if (idx_q == LAST) begin
                        state_q <= S_NSTART;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_NSTART: begin
                    start_q <= 1'b1;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_func_start   = fstart_q;
    assign o_busy         = busy_q;
    assign o_ibuf_we      = we_q;
    assign o_ibuf_wr_data = wdata_q;
    assign o_ibuf_addr    = addr_q;
    assign o_start        = start_q;

endmodule
